// File: rtl/dot_accum_stage_if.sv
// Handshake bundle for the dot-product stage: input pair stream, bias/abort
// controls, and the result stream toward the activation logic.
interface dot_accum_stage_if #(
  parameter int DATA_W = 16
);
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_w;
  logic [DATA_W-1:0] bias;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;

  modport master (
    output clr, in_valid, in_x, in_w, bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  clr, in_valid, in_x, in_w, bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/dot_accum_stage.sv
// Serial saturating multiply-accumulate for one neuron: N_TERMS fixed-point
// pairs are summed, bias is added, and the result is held until accepted.
module dot_accum_stage #(
  parameter int DATA_W  = 16,
  parameter int FRAC    = 8,
  parameter int N_TERMS = 8
) (
  input logic             clk,
  input logic             rst,
  dot_accum_stage_if.slave bus
);
  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(N_TERMS - 1);
  localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, BIAS, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  count;
  logic              sat_flag;
  logic              beat;

  logic signed [2*DATA_W-1:0] xe, we, prod, q;
  logic [DATA_W:0]            q_hi;
  logic [DATA_W-1:0]          q_clamp;
  logic                       q_sat;
  logic [DATA_W:0]            acc_sum, bias_sum;

  // {overflow, saturated sum}: overflow when operand signs agree but the sum's differs
  function automatic logic [DATA_W:0] sat_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    logic              ovf;
    s   = a + b;
    ovf = (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    if (ovf) s = a[DATA_W-1] ? MINV : MAXV;
    return {ovf, s};
  endfunction

  assign bus.in_ready = (state == ACCUM) && !bus.clr && !rst;
  assign beat         = bus.in_valid && bus.in_ready;

  always_comb begin
    xe   = (2*DATA_W)'($signed(bus.in_x));
    we   = (2*DATA_W)'($signed(bus.in_w));
    prod = xe * we;
    q    = prod >>> FRAC;
    // q fits in DATA_W bits only if its top DATA_W+1 bits are all equal
    q_hi    = q[2*DATA_W-1:DATA_W-1];
    q_sat   = !((&q_hi) || !(|q_hi));
    q_clamp = q_sat ? (q[2*DATA_W-1] ? MINV : MAXV) : q[DATA_W-1:0];
    acc_sum  = sat_add(acc, q_clamp);
    bias_sum = sat_add(acc, bus.bias);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (beat && count == LAST) state_nxt = BIAS;
      BIAS:    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      count         <= '0;
      sat_flag      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.clr) begin
            acc      <= '0;
            count    <= '0;
            sat_flag <= 1'b0;
          end else if (beat) begin
            acc      <= acc_sum[DATA_W-1:0];
            sat_flag <= sat_flag | q_sat | acc_sum[DATA_W];
            count    <= (count == LAST) ? '0 : count + 1'b1;
          end
        end
        BIAS: begin
          bus.out_data  <= bias_sum[DATA_W-1:0];
          bus.out_sat   <= sat_flag | bias_sum[DATA_W];
          bus.out_valid <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            acc           <= '0;
            sat_flag      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
